// File: rtl/mmcm_drp_rmw_seq_pkg.sv
// mmcm_drp_rmw_seq_pkg: shared state encoding, error codes and entry field widths
package mmcm_drp_rmw_seq_pkg;

    localparam int ADDR_W  = 7;
    localparam int DATA_W  = 16;
    localparam int ENTRY_W = ADDR_W + 2 * DATA_W;
    localparam int STATE_W = 4;

    localparam logic [STATE_W-1:0] S_IDLE      = 4'd0;
    localparam logic [STATE_W-1:0] S_RST       = 4'd1;
    localparam logic [STATE_W-1:0] S_RD_REQ    = 4'd2;
    localparam logic [STATE_W-1:0] S_RD_WAIT   = 4'd3;
    localparam logic [STATE_W-1:0] S_WR_REQ    = 4'd4;
    localparam logic [STATE_W-1:0] S_WR_WAIT   = 4'd5;
    localparam logic [STATE_W-1:0] S_NEXT      = 4'd6;
    localparam logic [STATE_W-1:0] S_RELEASE   = 4'd7;
    localparam logic [STATE_W-1:0] S_LOCK_WAIT = 4'd8;
    localparam logic [STATE_W-1:0] S_DONE      = 4'd9;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_DRDY = 2'd1;
    localparam logic [1:0] ERR_LOCK = 2'd2;

    // mask bits set to 1 keep the register's old value; data is already pre-masked
    function automatic logic [DATA_W-1:0] rmw_merge(
        input logic [DATA_W-1:0] old_val,
        input logic [DATA_W-1:0] mask,
        input logic [DATA_W-1:0] data
    );
        return (old_val & mask) | data;
    endfunction

endpackage

// File: rtl/mmcm_drp_rmw_table.sv
// mmcm_drp_rmw_table: {addr, mask, data} register file, sync write, comb read
module mmcm_drp_rmw_table
    import mmcm_drp_rmw_seq_pkg::*;
#(
    parameter int pNUM_ENTRIES = 8
) (
    input  logic                            clk_usb,
    input  logic                            we,
    input  logic [$clog2(pNUM_ENTRIES)-1:0] wr_idx,
    input  logic [ENTRY_W-1:0]              wr_entry,
    input  logic [$clog2(pNUM_ENTRIES)-1:0] rd_idx,
    output logic [ENTRY_W-1:0]              rd_entry
);

    logic [ENTRY_W-1:0] mem [pNUM_ENTRIES];

    // contents are deliberately not reset; only an idle-time write changes them
    always_ff @(posedge clk_usb) begin
        if (we) mem[wr_idx] <= wr_entry;
    end

    assign rd_entry = mem[rd_idx];

endmodule

// File: rtl/mmcm_drp_rmw_seq.sv
// mmcm_drp_rmw_seq: holds MMCM in reset, read-modify-writes DRP registers from a table, waits for lock
module mmcm_drp_rmw_seq
    import mmcm_drp_rmw_seq_pkg::*;
#(
    parameter int pNUM_ENTRIES  = 8,
    parameter int pDRDY_TIMEOUT = 63,
    parameter int pLOCK_TIMEOUT = 65535
) (
    input  logic                            clk_usb,
    input  logic                            reset_i,
    input  logic                            start_i,
    input  logic [$clog2(pNUM_ENTRIES):0]   num_entries_i,
    input  logic                            tbl_we_i,
    input  logic [$clog2(pNUM_ENTRIES)-1:0] tbl_idx_i,
    input  logic [6:0]                      tbl_addr_i,
    input  logic [15:0]                     tbl_mask_i,
    input  logic [15:0]                     tbl_data_i,
    output logic [6:0]                      drp_addr,
    output logic                            drp_den,
    output logic [15:0]                     drp_din,
    output logic                            drp_dwe,
    input  logic [15:0]                     drp_dout,
    input  logic                            drp_drdy,
    output logic                            mmcm_rst_o,
    input  logic                            mmcm_locked_i,
    output logic                            busy_o,
    output logic                            done_o,
    output logic [1:0]                      error_o
);

    localparam int IDX_W  = $clog2(pNUM_ENTRIES);
    localparam int CNT_W  = IDX_W + 1;
    localparam int DCNT_W = $clog2(pDRDY_TIMEOUT + 1);
    localparam int LCNT_W = $clog2(pLOCK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  MAX_CNT   = CNT_W'(pNUM_ENTRIES);
    localparam logic [DCNT_W-1:0] DRDY_LAST = DCNT_W'(pDRDY_TIMEOUT - 1);
    localparam logic [LCNT_W-1:0] LOCK_LAST = LCNT_W'(pLOCK_TIMEOUT - 1);

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] state_nx;
    logic [CNT_W-1:0]   idx;
    logic [CNT_W-1:0]   num;
    logic [DCNT_W-1:0]  dcnt;
    logic [LCNT_W-1:0]  lcnt;
    logic [ENTRY_W-1:0] entry;
    logic [ADDR_W-1:0]  e_addr;
    logic [DATA_W-1:0]  e_mask;
    logic [DATA_W-1:0]  e_data;
    logic               drdy_to;
    logic               lock_to;
    logic               in_wait;
    logic               start_go;

    assign {e_addr, e_mask, e_data} = entry;
    assign in_wait  = state == S_RD_WAIT || state == S_WR_WAIT;
    assign drdy_to  = dcnt == DRDY_LAST;
    assign lock_to  = lcnt == LOCK_LAST;
    assign start_go = state == S_IDLE && start_i;

    mmcm_drp_rmw_table #(.pNUM_ENTRIES(pNUM_ENTRIES)) u_table (
        .clk_usb  (clk_usb),
        .we       (tbl_we_i && state == S_IDLE),
        .wr_idx   (tbl_idx_i),
        .wr_entry ({tbl_addr_i, tbl_mask_i, tbl_data_i}),
        .rd_idx   (idx[IDX_W-1:0]),
        .rd_entry (entry)
    );

    // state register
    always_ff @(posedge clk_usb) begin
        if (reset_i) state <= S_IDLE;
        else         state <= state_nx;
    end

    // next-state logic; a drdy timeout releases reset and skips the lock wait
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:      state_nx = start_i ? S_RST : S_IDLE;
            S_RST:       state_nx = (num != '0) ? S_RD_REQ : S_RELEASE;
            S_RD_REQ:    state_nx = S_RD_WAIT;
            S_RD_WAIT:   state_nx = drp_drdy ? S_WR_REQ : drdy_to ? S_RELEASE : S_RD_WAIT;
            S_WR_REQ:    state_nx = S_WR_WAIT;
            S_WR_WAIT:   state_nx = drp_drdy ? S_NEXT : drdy_to ? S_RELEASE : S_WR_WAIT;
            S_NEXT:      state_nx = (idx + 1'b1 == num) ? S_RELEASE : S_RD_REQ;
            S_RELEASE:   state_nx = (error_o == ERR_DRDY) ? S_IDLE : S_LOCK_WAIT;
            S_LOCK_WAIT: state_nx = mmcm_locked_i ? S_DONE : lock_to ? S_IDLE : S_LOCK_WAIT;
            S_DONE:      state_nx = S_IDLE;
            default:     state_nx = S_IDLE;
        endcase
    end

    // outputs decoded from state; den lasts only the single request cycle
    always_comb begin
        drp_den    = state == S_RD_REQ || state == S_WR_REQ;
        drp_dwe    = state == S_WR_REQ;
        drp_addr   = (state inside {S_RD_REQ, S_RD_WAIT, S_WR_REQ, S_WR_WAIT}) ? e_addr : '0;
        mmcm_rst_o = state inside {S_RST, S_RD_REQ, S_RD_WAIT, S_WR_REQ, S_WR_WAIT, S_NEXT, S_RELEASE};
        busy_o     = state != S_IDLE;
        done_o     = state == S_DONE;
    end

    // datapath: entry index, sampled count, merged write data, timeout counters, sticky error
    always_ff @(posedge clk_usb) begin
        if (reset_i) begin
            idx     <= '0;
            num     <= '0;
            dcnt    <= '0;
            lcnt    <= '0;
            drp_din <= '0;
            error_o <= ERR_NONE;
        end else begin
            if (start_go) begin
                idx     <= '0;
                num     <= (num_entries_i > MAX_CNT) ? MAX_CNT : num_entries_i;
                error_o <= ERR_NONE;
            end
            if (drp_den) dcnt <= '0;
            else if (in_wait) dcnt <= dcnt + 1'b1;
            if (state == S_RD_WAIT && drp_drdy) drp_din <= rmw_merge(drp_dout, e_mask, e_data);
            if (in_wait && !drp_drdy && drdy_to) error_o <= ERR_DRDY;
            if (state == S_NEXT) idx <= idx + 1'b1;
            if (state == S_RELEASE) lcnt <= '0;
            else if (state == S_LOCK_WAIT) lcnt <= lcnt + 1'b1;
            if (state == S_LOCK_WAIT && !mmcm_locked_i && lock_to) error_o <= ERR_LOCK;
        end
    end

endmodule

// File: tb/tb_mmcm_drp_rmw_seq.sv
// tb_mmcm_drp_rmw_seq: directed checks of the DRP read-modify-write sequencer
module tb_mmcm_drp_rmw_seq;

    logic        clk_usb = 1'b0;
    logic        reset_i;
    logic        start_i;
    logic [3:0]  num_entries_i;
    logic        tbl_we_i;
    logic [2:0]  tbl_idx_i;
    logic [6:0]  tbl_addr_i;
    logic [15:0] tbl_mask_i;
    logic [15:0] tbl_data_i;
    logic [6:0]  drp_addr;
    logic        drp_den;
    logic [15:0] drp_din;
    logic        drp_dwe;
    logic [15:0] drp_dout;
    logic        drp_drdy;
    logic        mmcm_rst_o;
    logic        mmcm_locked_i;
    logic        busy_o;
    logic        done_o;
    logic [1:0]  error_o;

    mmcm_drp_rmw_seq dut (
        .clk_usb       (clk_usb),
        .reset_i       (reset_i),
        .start_i       (start_i),
        .num_entries_i (num_entries_i),
        .tbl_we_i      (tbl_we_i),
        .tbl_idx_i     (tbl_idx_i),
        .tbl_addr_i    (tbl_addr_i),
        .tbl_mask_i    (tbl_mask_i),
        .tbl_data_i    (tbl_data_i),
        .drp_addr      (drp_addr),
        .drp_den       (drp_den),
        .drp_din       (drp_din),
        .drp_dwe       (drp_dwe),
        .drp_dout      (drp_dout),
        .drp_drdy      (drp_drdy),
        .mmcm_rst_o    (mmcm_rst_o),
        .mmcm_locked_i (mmcm_locked_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .error_o       (error_o)
    );

    always #5 clk_usb = ~clk_usb;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // responder knobs, written only by the stimulus block
    int          dly;
    int          withhold_n;
    int          lock_dly;
    logic [15:0] rd_val;

    // responder state and logs, written only by the responder
    int          den_n, done_n, overlap, rst_viol, rst_cyc, pend_cnt, lock_cnt;
    logic        pend;
    logic [7:0]  log_aw  [32];
    logic [15:0] log_din [32];

    // DRP slave and MMCM lock model, observing the DUT at the falling edge
    always @(negedge clk_usb) begin
        if (reset_i) begin
            den_n = 0; done_n = 0; overlap = 0; rst_viol = 0; rst_cyc = 0;
            pend = 1'b0; pend_cnt = 0; lock_cnt = 0;
            drp_drdy = 1'b0; drp_dout = 16'h0; mmcm_locked_i = 1'b0;
        end else begin
            drp_drdy = 1'b0;
            if (pend) begin
                if (pend_cnt == 0) begin
                    drp_drdy = 1'b1;
                    drp_dout = rd_val;
                    pend = 1'b0;
                end else pend_cnt--;
            end
            if (drp_den) begin
                if (pend) overlap++;
                if (!mmcm_rst_o) rst_viol++;
                if (den_n < 32) begin
                    log_aw[den_n]  = {drp_dwe, drp_addr};
                    log_din[den_n] = drp_din;
                end
                den_n++;
                pend = 1'b1;
                pend_cnt = (den_n == withhold_n) ? 1000000 : dly;
            end
            if (drp_dwe && !drp_den) overlap++;
            if (mmcm_rst_o) rst_cyc++;
            if (done_o) done_n++;
            if (mmcm_rst_o) begin
                lock_cnt = 0;
                mmcm_locked_i = 1'b0;
            end else if (lock_dly >= 0 && lock_cnt >= lock_dly) mmcm_locked_i = 1'b1;
            else lock_cnt++;
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk_usb);
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        step(2);
        reset_i = 1'b0;
        step(1);
    endtask

    task automatic load(input int i, input logic [6:0] a, input logic [15:0] m, input logic [15:0] d);
        tbl_we_i = 1'b1; tbl_idx_i = 3'(i); tbl_addr_i = a; tbl_mask_i = m; tbl_data_i = d;
        step(1);
        tbl_we_i = 1'b0;
    endtask

    task automatic run(input int cnt, input int bound, output int cyc);
        num_entries_i = 4'(cnt);
        start_i = 1'b1;
        step(1);
        start_i = 1'b0;
        cyc = 1;
        while (cyc < bound && !done_o && error_o == 2'd0) begin
            step(1);
            cyc++;
        end
    endtask

    logic [7:0]  exp_aw  [6] = '{8'h08, 8'h88, 8'h09, 8'h89, 8'h0A, 8'h8A};
    logic [15:0] exp_din [3] = '{16'h0041, 16'hA123, 16'h55CD};

    initial begin
        int cyc;
        int k;
        reset_i = 1'b1; start_i = 1'b0; num_entries_i = '0; tbl_we_i = 1'b0;
        tbl_idx_i = '0; tbl_addr_i = '0; tbl_mask_i = '0; tbl_data_i = '0;
        dly = 0; withhold_n = 0; lock_dly = 10; rd_val = 16'h0;
        step(3);
        reset_i = 1'b0;
        step(1);
        chk("reset_outputs", {drp_addr, drp_den, drp_dwe, drp_din, mmcm_rst_o, busy_o, done_o, error_o}, 32'h0);

        // single entry read-modify-write
        load(0, 7'h08, 16'h1000, 16'h0041);
        rd_val = 16'hFFFF;
        run(1, 200, cyc);
        step(1);
        chk("t1_bound", cyc < 200, 1);
        chk("t1_den_n", den_n, 2);
        chk("t1_rd", log_aw[0], 8'h08);
        chk("t1_wr", log_aw[1], 8'h88);
        chk("t1_din", log_din[1], 16'h1041);
        chk("t1_done", done_n, 1);
        chk("t1_err", error_o, 0);
        chk("t1_busy", busy_o, 0);
        chk("t1_rst_held", rst_viol, 0);

        // three entries with slow drdy
        load(1, 7'h09, 16'hF000, 16'h0123);
        load(2, 7'h0A, 16'h00FF, 16'h5500);
        do_reset();
        dly = 5; rd_val = 16'hABCD;
        run(3, 500, cyc);
        step(1);
        chk("t2_bound", cyc < 500, 1);
        chk("t2_den_n", den_n, 6);
        for (int i = 0; i < 6; i++) chk($sformatf("t2_aw%0d", i), log_aw[i], exp_aw[i]);
        for (int i = 0; i < 3; i++) chk($sformatf("t2_din%0d", i), log_din[2*i+1], exp_din[i]);
        chk("t2_overlap", overlap, 0);
        chk("t2_done", done_n, 1);

        // drdy withheld on the second read
        do_reset();
        dly = 0; withhold_n = 3;
        run(3, 200, cyc);
        step(1);
        chk("t3_err", error_o, 1);
        chk("t3_time", cyc >= 68 && cyc <= 74, 1);
        chk("t3_den_n", den_n, 3);
        chk("t3_done", done_n, 0);
        chk("t3_rst_low", mmcm_rst_o, 0);
        chk("t3_busy", busy_o, 0);
        withhold_n = 0;

        // lock never arrives
        do_reset();
        lock_dly = -1;
        run(1, 70000, cyc);
        step(1);
        chk("t4_err", error_o, 2);
        chk("t4_time", cyc >= 65530 && cyc <= 65560, 1);
        chk("t4_busy", busy_o, 0);
        chk("t4_done", done_n, 0);
        lock_dly = 10;

        // empty table run
        do_reset();
        lock_dly = 3;
        run(0, 200, cyc);
        step(1);
        chk("t5_bound", cyc < 200, 1);
        chk("t5_den_n", den_n, 0);
        chk("t5_rst_cyc", rst_cyc, 2);
        chk("t5_done", done_n, 1);
        chk("t5_err", error_o, 0);
        lock_dly = 10;

        // start and table write while busy, then reset during WR_WAIT
        do_reset();
        dly = 5; rd_val = 16'hFFFF;
        num_entries_i = 4'd2;
        start_i = 1'b1;
        step(1);
        start_i = 1'b0;
        step(3);
        start_i = 1'b1;
        load(0, 7'h7F, 16'h0000, 16'hFFFF);
        start_i = 1'b0;
        k = 0;
        while (den_n < 2 && k < 100) begin
            step(1);
            k++;
        end
        chk("t6_wr_seen", den_n >= 2, 1);
        chk("t6_wr_addr", log_aw[1], 8'h88);
        chk("t6_wr_din", log_din[1], 16'h1041);
        step(1);
        reset_i = 1'b1;
        step(1);
        chk("t6_reset_outputs", {drp_addr, drp_den, drp_dwe, drp_din, mmcm_rst_o, busy_o, done_o, error_o}, 32'h0);
        reset_i = 1'b0;
        step(2);
        chk("t6_idle", busy_o, 0);
        do_reset();
        run(1, 200, cyc);
        step(1);
        chk("t6_tbl_addr", log_aw[0], 8'h08);
        chk("t6_tbl_din", log_din[1], 16'h1041);
        chk("t6_done", done_n, 1);

        // count above table depth saturates
        for (int i = 3; i < 8; i++) load(i, 7'(8'h10 + i), 16'h0000, 16'(i));
        do_reset();
        dly = 0;
        run(15, 500, cyc);
        step(1);
        chk("t7_den_n", den_n, 16);
        chk("t7_last_aw", log_aw[15], 8'h97);
        chk("t7_last_din", log_din[15], 16'h0007);
        chk("t7_done", done_n, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
